// File: rtl/cp_pkg.sv
// Shared types and widths for the cp_if_stage fetch slice.
//   XLEN / INSTR_W : address and instruction widths
//   if_state_e     : fetch stage FSM states
//   fetch_entry_t  : one buffered instruction with its PC
package cp_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [0:0] {
    BOOT,
    RUN
  } if_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/cp_sync_fifo.sv
// Synchronous FIFO with registered storage and an occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO at the next edge (wins over push/pop)
//   push/wdata : write side; a push into a full FIFO is honoured only with a pop
//   pop/rdata  : read side; rdata is the current head
//   empty      : no entries held
//   count      : number of entries held (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module cp_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok  = pop && (count_q != '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok = push && ((count_q < CNT_W'(DEPTH)) || pop_ok);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/cp_if_stage.sv
// Instruction fetch stage: producer side of the IF->ID valid/ready handshake.
//   clk, rst_n              : clock, asynchronous active-low reset
//   imem_req_*              : in-order word fetch requests (valid/ready, addr)
//   imem_rsp_*              : in-order responses, never back-pressured
//   instr_*_id              : buffered instruction + PC towards ID (valid/ready)
//   redirect_*_ex           : redirect from EX; flushes and restarts at target
//   fetch_stall_cnt_o       : only with CP_IF_STALL_CNT_EN defined; counts RUN
//                             cycles where ID is ready but nothing is buffered
// Optional build macro: CP_IF_STALL_CNT_EN.
module cp_if_stage import cp_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid_o,
  output logic [XLEN-1:0]    imem_req_addr_o,
  input  logic               imem_req_ready_i,
  input  logic               imem_rsp_valid_i,
  input  logic [INSTR_W-1:0] imem_rsp_data_i,
  output logic               instr_valid_id_o,
  input  logic               instr_ready_id_i,
  output logic [INSTR_W-1:0] instr_data_id_o,
  output logic [XLEN-1:0]    instr_pc_id_o,
  input  logic               redirect_valid_ex_i,
  input  logic [XLEN-1:0]    redirect_pc_ex_i
`ifdef CP_IF_STALL_CNT_EN
  ,
  output logic [31:0]        fetch_stall_cnt_o
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  if_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_sum;
  logic             fifo_empty;
  logic             req_valid, req_fire, rsp_drop, rsp_push, id_fire;
  logic [XLEN-1:0]  redirect_target;
  fetch_entry_t     push_entry, head_entry;

  // Credits cover both in-flight requests and buffered entries, so every
  // response always finds a free FIFO slot.
  assign credit_sum = {1'b0, outst_q} + {1'b0, fifo_count};
  assign req_valid  = (state_q == RUN) && (outst_q < CNT_W'(MAX_OUTSTANDING)) &&
                      (credit_sum < (CNT_W + 1)'(FIFO_DEPTH));
  assign req_fire   = req_valid && imem_req_ready_i;
  assign rsp_drop   = imem_rsp_valid_i && (drop_q != '0);
  assign rsp_push   = imem_rsp_valid_i && !rsp_drop && !redirect_valid_ex_i;
  assign id_fire    = !fifo_empty && instr_ready_id_i;

  assign redirect_target = redirect_pc_ex_i & ~XLEN'(3);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    outst_d  = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid_i);
    if (redirect_valid_ex_i) begin
      pc_d     = redirect_target;
      rsp_pc_d = redirect_target;
      // Everything still in flight after this edge belongs to the old path,
      // including a request accepted right now; a response arriving now has
      // already been retired (dropped or discarded) by the decrement above.
      drop_d   = outst_d;
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (rsp_push) rsp_pc_d = rsp_pc_q + XLEN'(4);
      if (rsp_drop) drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
    end
  end

  assign push_entry = '{instr: imem_rsp_data_i, pc: rsp_pc_q};

  cp_sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(redirect_valid_ex_i),
    .push (rsp_push),
    .wdata(push_entry),
    .pop  (id_fire),
    .rdata(head_entry),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = pc_q;
  assign instr_valid_id_o = !fifo_empty;
  assign instr_data_id_o  = head_entry.instr;
  assign instr_pc_id_o    = head_entry.pc;

`ifdef CP_IF_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if ((state_q == RUN) && instr_ready_id_i && fifo_empty &&
                 (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cp_if_stage.sv
// Self-checking bench for cp_if_stage: behavioural imem with configurable
// latency, ID handshake monitor, and an expected-instruction scoreboard.
`timescale 1ns/1ps
module tb_cp_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        instr_valid_id_o;
  logic        id_ready;
  logic [31:0] instr_data_id_o;
  logic [31:0] instr_pc_id_o;
  logic        redir_v;
  logic [31:0] redir_pc;
`ifdef CP_IF_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  cp_if_stage dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem_req_valid_o   (imem_req_valid_o),
    .imem_req_addr_o    (imem_req_addr_o),
    .imem_req_ready_i   (imem_ready),
    .imem_rsp_valid_i   (rsp_valid),
    .imem_rsp_data_i    (rsp_data),
    .instr_valid_id_o   (instr_valid_id_o),
    .instr_ready_id_i   (id_ready),
    .instr_data_id_o    (instr_data_id_o),
    .instr_pc_id_o      (instr_pc_id_o),
    .redirect_valid_ex_i(redir_v),
    .redirect_pc_ex_i   (redir_pc)
`ifdef CP_IF_STALL_CNT_EN
    ,
    .fetch_stall_cnt_o  (stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          cyc;
  } obs_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  obs_t  obs_q[$];
  obs_t  exp_q[$];
  pend_t pend_q[$];
  int    vec_cnt = 0;
  int    err_cnt = 0;
  int    lat     = 1;
  int    req_cnt = 0;
  int    cyc     = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic push_exp(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pc: start + 32'(i * 4), data: mem_f(start + 32'(i * 4)), cyc: 0});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: accepts on valid&&ready, answers in order after lat edges.
  initial begin : imem_model
    logic        fire;
    logic [31:0] fa;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    forever begin
      @(negedge clk);
      fire = rst_n && imem_req_valid_o && imem_ready;
      fa   = imem_req_addr_o;
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pend_q.delete();
        rsp_valid = 1'b0;
        rsp_data  = '0;
      end else begin
        if (fire) begin
          pend_q.push_back('{addr: fa, due: cyc + lat - 1});
          req_cnt++;
        end
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          rsp_valid = 1'b1;
          rsp_data  = mem_f(pend_q[0].addr);
          void'(pend_q.pop_front());
        end else begin
          rsp_valid = 1'b0;
          rsp_data  = '0;
        end
      end
    end
  end

  // ID-side monitor; the redirect-cycle handshake belongs to the squashed path.
  initial begin : id_monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && instr_valid_id_o === 1'b1 && id_ready && !redir_v) begin
        obs_q.push_back('{pc: instr_pc_id_o, data: instr_data_id_o, cyc: cyc});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset(input int lat_i);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    redir_v = 1'b0;
    lat     = lat_i;
    obs_q.delete();
    exp_q.delete();
    tick(2);
    rst_n   = 1'b1;
    req_cnt = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (imem_req_valid_o !== 1'b0) begin
      err_cnt++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid_o);
    end
    vec_cnt++;
    if (imem_req_addr_o !== 32'h0) begin
      err_cnt++; $display("FAIL reset_req_addr: got %h want 00000000", imem_req_addr_o);
    end
    vec_cnt++;
    if (instr_valid_id_o !== 1'b0) begin
      err_cnt++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid_id_o);
    end
    vec_cnt++;
    if (instr_data_id_o !== 32'h0 || instr_pc_id_o !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_instr_out: got data %h pc %h want 0 0", instr_data_id_o, instr_pc_id_o);
    end
`ifdef CP_IF_STALL_CNT_EN
    vec_cnt++;
    if (stall_cnt !== 32'h0) begin
      err_cnt++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (imem_req_valid_o !== 1'b0) begin
      err_cnt++; $display("FAIL boot_no_req: got %b want 0", imem_req_valid_o);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    vec_cnt++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h0) begin
      err_cnt++;
      $display("FAIL first_req: got valid %b addr %h want 1 00000000",
               imem_req_valid_o, imem_req_addr_o);
    end
  endtask

  task automatic test_stream;
    int c_first = 0;
    int c_last  = 0;
    do_reset(1);
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    push_exp(32'h0, 16);
    tick(30);
    for (int i = 0; i < 16; i++) begin
      obs_t o;
      obs_t e;
      e = exp_q.pop_front();
      vec_cnt++;
      if (obs_q.size() == 0) begin
        err_cnt++; $display("FAIL stream[%0d]: got nothing want pc %h", i, e.pc);
      end else begin
        o = obs_q.pop_front();
        if (i == 0) c_first = o.cyc;
        if (i == 15) c_last = o.cyc;
        if (o.pc !== e.pc || o.data !== e.data) begin
          err_cnt++;
          $display("FAIL stream[%0d]: got pc %h data %h want pc %h data %h",
                   i, o.pc, o.data, e.pc, e.data);
        end
      end
    end
    vec_cnt++;
    if (c_last - c_first !== 15) begin
      err_cnt++; $display("FAIL stream_rate: got span %0d want 15", c_last - c_first);
    end
  endtask

  task automatic test_backpressure;
    do_reset(1);
    imem_ready = 1'b1;
    id_ready   = 1'b0;
    tick(20);
    vec_cnt++;
    if (req_cnt !== 4) begin
      err_cnt++; $display("FAIL bp_req_count: got %0d want 4", req_cnt);
    end
    vec_cnt++;
    if (imem_req_valid_o !== 1'b0) begin
      err_cnt++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid_o);
    end
    vec_cnt++;
    if (instr_valid_id_o !== 1'b1 || instr_pc_id_o !== 32'h0 || instr_data_id_o !== mem_f(0)) begin
      err_cnt++;
      $display("FAIL bp_head: got v %b pc %h data %h want 1 00000000 %h",
               instr_valid_id_o, instr_pc_id_o, instr_data_id_o, mem_f(0));
    end
    tick(3);
    vec_cnt++;
    if (instr_pc_id_o !== 32'h0 || instr_data_id_o !== mem_f(0)) begin
      err_cnt++;
      $display("FAIL bp_stable: got pc %h data %h want 00000000 %h",
               instr_pc_id_o, instr_data_id_o, mem_f(0));
    end
    push_exp(32'h0, 12);
    id_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    imem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      obs_t o;
      obs_t e;
      e = exp_q.pop_front();
      vec_cnt++;
      if (obs_q.size() == 0) begin
        err_cnt++; $display("FAIL bp_drain[%0d]: got nothing want pc %h", i, e.pc);
      end else begin
        o = obs_q.pop_front();
        if (o.pc !== e.pc || o.data !== e.data) begin
          err_cnt++;
          $display("FAIL bp_drain[%0d]: got pc %h data %h want pc %h data %h",
                   i, o.pc, o.data, e.pc, e.data);
        end
      end
    end
  endtask

  task automatic test_redirect;
    int waited = 0;
    do_reset(4);
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    while (pend_q.size() != 2 && waited < 20) begin
      tick(1);
      waited++;
    end
    vec_cnt++;
    if (pend_q.size() != 2) begin
      err_cnt++; $display("FAIL redir_setup: got %0d outstanding want 2", pend_q.size());
    end
    vec_cnt++;
    if (obs_q.size() != 0) begin
      err_cnt++; $display("FAIL redir_early: got %0d instrs want 0", obs_q.size());
    end
    redir_v  = 1'b1;
    redir_pc = 32'h0000_0100;
    push_exp(32'h100, 6);
    tick(1);
    redir_v = 1'b0;
    tick(40);
    for (int i = 0; i < 6; i++) begin
      obs_t o;
      obs_t e;
      e = exp_q.pop_front();
      vec_cnt++;
      if (obs_q.size() == 0) begin
        err_cnt++; $display("FAIL redir[%0d]: got nothing want pc %h", i, e.pc);
      end else begin
        o = obs_q.pop_front();
        if (o.pc !== e.pc || o.data !== e.data) begin
          err_cnt++;
          $display("FAIL redir[%0d]: got pc %h data %h want pc %h data %h",
                   i, o.pc, o.data, e.pc, e.data);
        end
      end
    end
  endtask

  task automatic test_collide;
    do_reset(1);
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    push_exp(32'h0, 6);
    tick(10);
    for (int i = 0; i < 6; i++) begin
      obs_t o;
      obs_t e;
      e = exp_q.pop_front();
      vec_cnt++;
      if (obs_q.size() == 0) begin
        err_cnt++; $display("FAIL coll_pre[%0d]: got nothing want pc %h", i, e.pc);
      end else begin
        o = obs_q.pop_front();
        if (o.pc !== e.pc || o.data !== e.data) begin
          err_cnt++;
          $display("FAIL coll_pre[%0d]: got pc %h data %h want pc %h data %h",
                   i, o.pc, o.data, e.pc, e.data);
        end
      end
    end
    obs_q.delete();
    redir_v  = 1'b1;
    redir_pc = 32'h0000_0400;
    push_exp(32'h400, 8);
    @(negedge clk);
    vec_cnt++;
    if (imem_req_valid_o !== 1'b1 || rsp_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL coll_setup: got req %b rsp %b want 1 1", imem_req_valid_o, rsp_valid);
    end
    @(posedge clk);
    #1;
    redir_v = 1'b0;
    tick(25);
    for (int i = 0; i < 8; i++) begin
      obs_t o;
      obs_t e;
      e = exp_q.pop_front();
      vec_cnt++;
      if (obs_q.size() == 0) begin
        err_cnt++; $display("FAIL coll[%0d]: got nothing want pc %h", i, e.pc);
      end else begin
        o = obs_q.pop_front();
        if (o.pc !== e.pc || o.data !== e.data) begin
          err_cnt++;
          $display("FAIL coll[%0d]: got pc %h data %h want pc %h data %h",
                   i, o.pc, o.data, e.pc, e.data);
        end
      end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] tgt  [2];
    logic [31:0] base [2];
    tgt[0]  = 32'h0000_0202;
    base[0] = 32'h0000_0200;
    tgt[1]  = 32'hFFFF_FFFE;
    base[1] = 32'hFFFF_FFFC;
    do_reset(2);
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    tick(6);
    for (int r = 0; r < 2; r++) begin
      obs_q.delete();
      exp_q.delete();
      redir_v  = 1'b1;
      redir_pc = tgt[r];
      push_exp(base[r], 4);
      tick(1);
      redir_v = 1'b0;
      tick(20);
      for (int i = 0; i < 4; i++) begin
        obs_t o;
        obs_t e;
        e = exp_q.pop_front();
        vec_cnt++;
        if (obs_q.size() == 0) begin
          err_cnt++; $display("FAIL wrap%0d[%0d]: got nothing want pc %h", r, i, e.pc);
        end else begin
          o = obs_q.pop_front();
          if (o.pc !== e.pc || o.data !== e.data) begin
            err_cnt++;
            $display("FAIL wrap%0d[%0d]: got pc %h data %h want pc %h data %h",
                     r, i, o.pc, o.data, e.pc, e.data);
          end
        end
      end
    end
  endtask

`ifdef CP_IF_STALL_CNT_EN
  task automatic test_stall_cnt;
    int exp_stall = 0;
    do_reset(5);
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (instr_valid_id_o !== 1'b1) exp_stall++;
    end
    @(posedge clk);
    #1;
    vec_cnt++;
    if (stall_cnt !== 32'(exp_stall)) begin
      err_cnt++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_stall);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (stall_cnt !== 32'h0) begin
      err_cnt++; $display("FAIL stall_cnt_reset: got %0d want 0", stall_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    imem_ready = 1'b1;
    id_ready   = 1'b0;
    redir_v    = 1'b0;
    redir_pc   = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_collide();
    test_wrap();
`ifdef CP_IF_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
